// File: rtl/sdrc_wb_arbiter.sv
// Round-robin Wishbone arbiter in front of the sdrc_top slave port.
// Grants are locked for a master's whole cycle; a watchdog aborts stalled strobes.
module sdrc_wb_arbiter #(
   parameter int NUM_M   = 4,
   parameter int AW      = 26,
   parameter int DW      = 8,
   parameter int TIMEOUT = 255
) (
   input  logic                    wb_clk_i,
   input  logic                    wb_rst_i,
   input  logic                    sdr_init_done,
   input  logic [NUM_M-1:0]        m_cyc_i,
   input  logic [NUM_M-1:0]        m_stb_i,
   input  logic [NUM_M-1:0]        m_we_i,
   input  logic [NUM_M*AW-1:0]     m_addr_i,
   input  logic [NUM_M*DW-1:0]     m_dat_i,
   input  logic [NUM_M*DW/8-1:0]   m_sel_i,
   input  logic [NUM_M*3-1:0]      m_cti_i,
   output logic [DW-1:0]           m_dat_o,
   output logic [NUM_M-1:0]        m_ack_o,
   output logic [NUM_M-1:0]        m_err_o,
   output logic [NUM_M-1:0]        grant_o,
   output logic                    s_cyc_o,
   output logic                    s_stb_o,
   output logic                    s_we_o,
   output logic [AW-1:0]           s_addr_o,
   output logic [DW-1:0]           s_dat_o,
   output logic [DW/8-1:0]         s_sel_o,
   output logic [2:0]              s_cti_o,
   input  logic                    s_ack_i,
   input  logic [DW-1:0]           s_dat_i
);

   localparam int            IW       = (NUM_M > 1) ? $clog2(NUM_M) : 1;
   localparam int            SW       = DW / 8;
   localparam logic [7:0]    WD_LIMIT = 8'(TIMEOUT);
   localparam bit            WD_EN    = (TIMEOUT != 0);
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_M - 1);

   typedef enum logic [1:0] {IDLE, BUSY, ABORT, WAIT_REL} state_t;

   state_t           state, state_n;
   logic [IW-1:0]    own, own_n;
   logic [IW-1:0]    last, last_n;
   logic [NUM_M-1:0] grant_n;
   logic [7:0]       wd_cnt, wd_cnt_n;
   logic [IW-1:0]    winner;
   logic             winner_vld;
   int               cand;

   // Round-robin search upward from last+1; the first hit wins.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      winner     = '0;
      winner_vld = 1'b0;
      cand       = 0;
      for (int i = 1; i <= NUM_M; i++) begin
         cand = int'(last) + i;
         if (cand >= NUM_M) cand = cand - NUM_M;
         if (!winner_vld && m_cyc_i[IW'(cand)]) begin
            winner     = IW'(cand);
            winner_vld = 1'b1;
         end
      end
   end

   // Slave-side mux and master-side response routing.
   always_comb begin
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      s_addr_o = '0;
      s_dat_o  = '0;
      s_sel_o  = '0;
      s_cti_o  = '0;
      m_ack_o  = '0;
      m_err_o  = '0;
      case (state)
         BUSY: begin
            s_cyc_o      = m_cyc_i[own];
            s_stb_o      = m_stb_i[own];
            s_we_o       = m_we_i[own];
            s_addr_o     = m_addr_i[int'(own)*AW +: AW];
            s_dat_o      = m_dat_i[int'(own)*DW +: DW];
            s_sel_o      = m_sel_i[int'(own)*SW +: SW];
            s_cti_o      = m_cti_i[int'(own)*3 +: 3];
            m_ack_o[own] = s_ack_i;
         end
         ABORT:   m_err_o[own] = 1'b1;
         default: ;
      endcase
   end

   assign m_dat_o = s_dat_i;

   always_comb begin
      state_n  = state;
      own_n    = own;
      last_n   = last;
      grant_n  = grant_o;
      wd_cnt_n = wd_cnt;
      case (state)
         IDLE: begin
            wd_cnt_n = '0;
            if (sdr_init_done && winner_vld) begin
               state_n         = BUSY;
               own_n           = winner;
               last_n          = winner;
               grant_n         = '0;
               grant_n[winner] = 1'b1;
            end
         end
         BUSY: begin
            // A released cycle takes precedence over a watchdog hit on the same edge.
            if (!m_cyc_i[own]) begin
               state_n  = IDLE;
               grant_n  = '0;
               wd_cnt_n = '0;
            end else if (WD_EN && (wd_cnt == WD_LIMIT)) begin
               state_n  = ABORT;
               wd_cnt_n = '0;
            end else if (s_stb_o && !s_ack_i) begin
               if (wd_cnt != 8'hFF) wd_cnt_n = wd_cnt + 8'd1;
            end else begin
               wd_cnt_n = '0;
            end
         end
         ABORT: begin
            if (!m_cyc_i[own]) begin
               state_n = IDLE;
               grant_n = '0;
            end else begin
               state_n = WAIT_REL;
            end
         end
         WAIT_REL: begin
            if (!m_cyc_i[own]) begin
               state_n = IDLE;
               grant_n = '0;
            end
         end
         default: begin
            state_n = IDLE;
            grant_n = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (wb_rst_i) begin
         state   <= IDLE;
         own     <= '0;
         last    <= LAST_RST;
         grant_o <= '0;
         wd_cnt  <= '0;
      end else begin
         state   <= state_n;
         own     <= own_n;
         last    <= last_n;
         grant_o <= grant_n;
         wd_cnt  <= wd_cnt_n;
      end
   end

endmodule

// File: tb/tb_sdrc_wb_arbiter.sv
// Scoreboard bench for sdrc_wb_arbiter: directed master programs feed expected
// grants, slave transfers and aborts into queues that a negedge monitor drains.
module tb_sdrc_wb_arbiter;

   localparam int NM = 4;
   localparam int AW = 26;
   localparam int DW = 8;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] dat;
      logic          sel;
      logic [2:0]    cti;
   } beat_t;

   logic              wb_clk_i = 1'b0;
   logic              wb_rst_i;
   logic              sdr_init_done;
   logic [NM-1:0]     m_cyc_i, m_stb_i, m_we_i;
   logic [NM*AW-1:0]  m_addr_i;
   logic [NM*DW-1:0]  m_dat_i;
   logic [NM-1:0]     m_sel_i;
   logic [NM*3-1:0]   m_cti_i;
   logic [DW-1:0]     m_dat_o;
   logic [NM-1:0]     m_ack_o, m_err_o, grant_o;
   logic              s_cyc_o, s_stb_o, s_we_o;
   logic [AW-1:0]     s_addr_o;
   logic [DW-1:0]     s_dat_o;
   logic              s_sel_o;
   logic [2:0]        s_cti_o;
   logic              s_ack_i;
   logic [DW-1:0]     s_dat_i;

   logic              ack_en, ack_force;
   logic [NM-1:0]     ack_s;
   logic [NM-1:0]     gap, hold;
   beat_t             jobs [NM][$];
   beat_t             xfer_q [$];
   logic [NM-1:0]     grant_q [$];
   logic [NM-1:0]     err_mask_q [$];
   int                err_cyc_q [$];
   int                n_checks = 0;
   int                n_pass = 0;
   int                cyc_cnt = 0;

   // Slave model: immediate ack while enabled, or a forced stray ack.
   assign s_ack_i = ack_force | (ack_en & s_cyc_o & s_stb_o);

   sdrc_wb_arbiter #(.NUM_M(NM), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .sdr_init_done(sdr_init_done),
      .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
      .m_addr_i(m_addr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_cti_i(m_cti_i),
      .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .grant_o(grant_o),
      .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
      .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_cti_o(s_cti_o),
      .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic beat_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] dat, input logic [2:0] cti);
      beat_t b;
      b.we = we; b.addr = addr; b.dat = dat; b.sel = 1'b1; b.cti = cti;
      return b;
   endfunction

   function automatic bit all_idle();
      for (int i = 0; i < NM; i++)
         if (jobs[i].size() > 0 || gap[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic tick();
      @(negedge wb_clk_i);
      ack_s = m_ack_o;
      @(posedge wb_clk_i);
      #1;
   endtask

   // Each master presents its head beat; after finishing a cycle it drops cyc for one tick.
   task automatic drive();
      beat_t b;
      logic  c, s;
      for (int i = 0; i < NM; i++) begin
         b = '0; c = 1'b0; s = 1'b0;
         if (gap[i]) gap[i] = 1'b0;
         else if (jobs[i].size() > 0) begin b = jobs[i][0]; c = 1'b1; s = 1'b1; end
         else if (hold[i]) c = 1'b1;
         m_cyc_i[i] = c;
         m_stb_i[i] = s;
         m_we_i[i]  = b.we;
         m_sel_i[i] = b.sel;
         m_addr_i[i*AW +: AW] = b.addr;
         m_dat_i[i*DW +: DW]  = b.dat;
         m_cti_i[i*3 +: 3]    = b.cti;
      end
   endtask

   task automatic process_acks();
      beat_t b;
      for (int i = 0; i < NM; i++) begin
         if (ack_s[i] && jobs[i].size() > 0) begin
            b = jobs[i].pop_front();
            if (b.cti == 3'b000 || b.cti == 3'b111) gap[i] = 1'b1;
         end
      end
   endtask

   task automatic run_masters(input int max_cyc, input bit must_drain);
      int n;
      n = 0;
      while (n < max_cyc) begin
         drive();
         tick();
         process_acks();
         n++;
         if (all_idle()) break;
      end
      if (must_drain) check(all_idle(), "drain_budget", 64'(n), 64'(max_cyc));
      drive();
   endtask

   task automatic check_reset_outputs(input string name);
      logic [63:0] v;
      v = 64'({grant_o, m_ack_o, m_err_o, s_cyc_o, s_stb_o, s_we_o,
               s_addr_o, s_dat_o, s_sel_o, s_cti_o});
      check(v == 64'd0, name, v, 64'd0);
   endtask

   task automatic pulse_reset();
      wb_rst_i = 1'b1;
      tick();
      check_reset_outputs("reset_outputs");
      wb_rst_i = 1'b0;
   endtask

   // Monitor: compares every DUT event against the head of its expectation queue.
   initial begin
      logic [NM-1:0] prev_grant, prev_err, exp_owner, eg;
      beat_t         e;
      int            ec;
      prev_grant = '0; prev_err = '0; exp_owner = '0;
      forever begin
         @(negedge wb_clk_i);
         cyc_cnt++;
         if (!wb_rst_i) begin
            if (grant_o != prev_grant && grant_o != '0) begin
               check(prev_grant == '0, "idle_gap", 64'(prev_grant), 64'd0);
               check(grant_q.size() > 0, "grant_unexpected", 64'(grant_o), 64'd0);
               if (grant_q.size() > 0) begin
                  eg = grant_q.pop_front();
                  check(grant_o == eg, "grant_order", 64'(grant_o), 64'(eg));
                  exp_owner = eg;
               end
            end
            if (m_ack_o != '0)
               check(m_ack_o == exp_owner, "ack_owner", 64'(m_ack_o), 64'(exp_owner));
            if (s_cyc_o && s_stb_o && s_ack_i) begin
               check(xfer_q.size() > 0, "xfer_unexpected", 64'(s_addr_o), 64'd0);
               if (xfer_q.size() > 0) begin
                  e = xfer_q.pop_front();
                  check({s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o} == e, "xfer",
                        64'({s_we_o, s_addr_o, s_dat_o, s_sel_o, s_cti_o}), 64'(e));
               end
               check(m_dat_o == s_dat_i, "rd_data", 64'(m_dat_o), 64'(s_dat_i));
            end
            if (prev_err != '0)
               check(m_err_o == '0, "err_pulse_len", 64'(m_err_o), 64'd0);
            if (m_err_o != '0) begin
               check(s_cyc_o == 1'b0, "abort_cyc", 64'(s_cyc_o), 64'd0);
               check(err_mask_q.size() > 0, "err_unexpected", 64'(m_err_o), 64'd0);
               if (err_mask_q.size() > 0) begin
                  eg = err_mask_q.pop_front();
                  ec = err_cyc_q.pop_front();
                  check(m_err_o == eg, "err_mask", 64'(m_err_o), 64'(eg));
                  check(cyc_cnt == ec, "err_cycle", 64'(cyc_cnt), 64'(ec));
               end
            end
         end
         prev_grant = grant_o;
         prev_err   = m_err_o;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int p;
      wb_rst_i = 1'b1; sdr_init_done = 1'b0;
      m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
      m_addr_i = '0; m_dat_i = '0; m_cti_i = '0;
      s_dat_i = 8'h5A; ack_en = 1'b1; ack_force = 1'b0;
      ack_s = '0; gap = '0; hold = '0;
      tick();
      pulse_reset();

      // Init gating: a pending request waits for sdr_init_done.
      jobs[0].push_back(mk(1'b1, 26'h0000001, 8'h11, 3'b000));
      xfer_q.push_back(mk(1'b1, 26'h0000001, 8'h11, 3'b000));
      grant_q.push_back(4'b0001);
      drive();
      for (int i = 0; i < 20; i++) begin
         tick();
         check(grant_o == '0 && !s_cyc_o, "init_hold", 64'({grant_o, s_cyc_o}), 64'd0);
      end
      sdr_init_done = 1'b1;
      tick();
      check(grant_o == 4'b0001, "init_grant", 64'(grant_o), 64'h1);
      run_masters(40, 1'b1);

      // Four simultaneous requesters; master 0 re-requests right after release.
      pulse_reset();
      for (int i = 0; i < NM; i++) begin
         jobs[i].push_back(mk(1'b1, AW'(26'h10 + i), DW'(8'h50 + i), 3'b000));
      end
      jobs[0].push_back(mk(1'b1, 26'h14, 8'h54, 3'b000));
      for (int i = 0; i < NM; i++) begin
         xfer_q.push_back(mk(1'b1, AW'(26'h10 + i), DW'(8'h50 + i), 3'b000));
         grant_q.push_back(NM'(1) << i);
      end
      xfer_q.push_back(mk(1'b1, 26'h14, 8'h54, 3'b000));
      grant_q.push_back(4'b0001);
      run_masters(80, 1'b1);

      // Master 2 incrementing burst; master 1 arrives a cycle later and must wait.
      for (int k = 0; k < 4; k++) begin
         jobs[2].push_back(mk(1'b1, AW'(26'h100 + k), DW'(8'hA0 + k), (k == 3) ? 3'b111 : 3'b010));
         xfer_q.push_back(mk(1'b1, AW'(26'h100 + k), DW'(8'hA0 + k), (k == 3) ? 3'b111 : 3'b010));
      end
      grant_q.push_back(4'b0100);
      run_masters(1, 1'b0);
      jobs[1].push_back(mk(1'b0, 26'h20, 8'h61, 3'b000));
      xfer_q.push_back(mk(1'b0, 26'h20, 8'h61, 3'b000));
      grant_q.push_back(4'b0010);
      run_masters(60, 1'b1);

      // Watchdog: slave never acks master 2.
      ack_en = 1'b0;
      jobs[2].push_back(mk(1'b1, 26'h2222, 8'h77, 3'b000));
      grant_q.push_back(4'b0100);
      drive();
      p = cyc_cnt;
      err_mask_q.push_back(4'b0100);
      err_cyc_q.push_back(p + 11);
      repeat (12) tick();
      check(!s_cyc_o && !s_stb_o, "wait_rel_slave", 64'({s_cyc_o, s_stb_o}), 64'd0);
      ack_force = 1'b1;
      #1;
      check(m_ack_o == '0, "late_ack", 64'(m_ack_o), 64'd0);
      tick();
      check(m_ack_o == '0 && !s_cyc_o, "late_ack_hold", 64'({m_ack_o, s_cyc_o}), 64'd0);
      ack_force = 1'b0;
      jobs[2].delete();
      drive();
      tick();
      check(grant_o == '0, "abort_release", 64'(grant_o), 64'd0);
      ack_en = 1'b1;

      // Reset while master 1 holds a burst open; afterwards master 0 beats master 3.
      jobs[1].push_back(mk(1'b1, 26'h200, 8'hB0, 3'b010));
      jobs[1].push_back(mk(1'b1, 26'h201, 8'hB1, 3'b010));
      xfer_q.push_back(mk(1'b1, 26'h200, 8'hB0, 3'b010));
      xfer_q.push_back(mk(1'b1, 26'h201, 8'hB1, 3'b010));
      grant_q.push_back(4'b0010);
      hold[1] = 1'b1;
      run_masters(20, 1'b1);
      wb_rst_i = 1'b1;
      tick();
      check_reset_outputs("reset_mid_burst");
      wb_rst_i = 1'b0;
      hold[1] = 1'b0;
      jobs[0].push_back(mk(1'b1, 26'h300, 8'hC0, 3'b000));
      jobs[3].push_back(mk(1'b0, 26'h303, 8'hC3, 3'b000));
      xfer_q.push_back(mk(1'b1, 26'h300, 8'hC0, 3'b000));
      xfer_q.push_back(mk(1'b0, 26'h303, 8'hC3, 3'b000));
      grant_q.push_back(4'b0001);
      grant_q.push_back(4'b1000);
      run_masters(40, 1'b1);
      repeat (3) tick();

      check(grant_q.size() == 0, "grant_q_drained", 64'(grant_q.size()), 64'd0);
      check(xfer_q.size() == 0, "xfer_q_drained", 64'(xfer_q.size()), 64'd0);
      check(err_mask_q.size() == 0, "err_q_drained", 64'(err_mask_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
